// File: rtl/reorder_buffer_pkg.sv
// Shared ROB types: entry width constants, instruction type codes and the entry record.
package reorder_buffer_pkg;

   localparam int ROB_BIT_DEF = 5;
   localparam int REG_W       = 5;
   localparam int XLEN        = 32;

   typedef enum logic [1:0] {
      ROB_REG   = 2'd0,
      ROB_STORE = 2'd1,
      ROB_BR    = 2'd2,
      ROB_EXIT  = 2'd3
   } rob_type_e;

   typedef struct packed {
      logic             busy;
      logic             ready;
      rob_type_e        rtype;
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  pc;
      logic             pred_taken;
      logic             taken;
      logic [XLEN-1:0]  val;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_bypass.sv
// Operand lookup for one query port: entry result, or the value on a CDB tagging it this cycle.
module rob_bypass
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_BIT = ROB_BIT_DEF
) (
   input  logic [ROB_BIT-1:0] q_entry_i,
   input  logic               entry_busy_i,
   input  logic               entry_ready_i,
   input  logic [XLEN-1:0]    entry_val_i,
   input  logic               alu_valid_i,
   input  logic [ROB_BIT-1:0] alu_rob_entry_i,
   input  logic [XLEN-1:0]    alu_val_i,
   input  logic               lsb_valid_i,
   input  logic [ROB_BIT-1:0] lsb_rob_entry_i,
   input  logic [XLEN-1:0]    lsb_val_i,
   output logic               q_ready_o,
   output logic [XLEN-1:0]    q_val_o
);

   logic alu_hit;
   logic lsb_hit;

   assign alu_hit   = alu_valid_i && (alu_rob_entry_i == q_entry_i);
   assign lsb_hit   = lsb_valid_i && (lsb_rob_entry_i == q_entry_i);
   assign q_ready_o = entry_busy_i && (entry_ready_i || alu_hit || lsb_hit);

   // LSB takes priority, matching the writeback path.
   always_comb begin
      q_val_o = entry_val_i;
      if (entry_busy_i && lsb_hit) begin
         q_val_o = lsb_val_i;
      end else if (entry_busy_i && alu_hit) begin
         q_val_o = alu_val_i;
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order issue, CDB writeback, in-order commit and mispredict flush.
// Optional ROB_STATS_EN adds stat_commits / stat_flushes counters.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_BIT = ROB_BIT_DEF
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic               issue_valid,
   input  logic [1:0]         issue_type,
   input  logic [REG_W-1:0]   issue_rd,
   input  logic [XLEN-1:0]    issue_pc,
   input  logic               issue_pred_taken,
   input  logic               issue_ready,
   input  logic [XLEN-1:0]    issue_val,
   output logic [ROB_BIT-1:0] issue_rob_entry,
   output logic               rob_full,
   input  logic               alu_valid,
   input  logic [ROB_BIT-1:0] alu_rob_entry,
   input  logic [XLEN-1:0]    alu_val,
   input  logic               alu_taken,
   input  logic               lsb_valid,
   input  logic [ROB_BIT-1:0] lsb_rob_entry,
   input  logic [XLEN-1:0]    lsb_val,
   input  logic [ROB_BIT-1:0] q1_entry,
   input  logic [ROB_BIT-1:0] q2_entry,
   output logic               q1_ready,
   output logic               q2_ready,
   output logic [XLEN-1:0]    q1_val,
   output logic [XLEN-1:0]    q2_val,
   output logic               commit_valid,
   output logic [REG_W-1:0]   commit_reg_id,
   output logic [XLEN-1:0]    commit_reg_data,
   output logic [ROB_BIT-1:0] commit_rob_entry,
   output logic               commit_store,
   output logic               rob_clear_up,
   output logic [XLEN-1:0]    redirect_pc,
   output logic               halt
`ifdef ROB_STATS_EN
   ,
   output logic [31:0]        stat_commits,
   output logic [31:0]        stat_flushes
`endif
);

   localparam int ROB_SIZE = 1 << ROB_BIT;

   rob_entry_t         ent_q [ROB_SIZE];
   rob_entry_t         ent_d [ROB_SIZE];
   rob_entry_t         head_ent;
   logic [ROB_BIT-1:0] head_q, head_d, tail_q, tail_d;
   logic [ROB_BIT:0]   count_q, count_d;
   logic               halt_q, halt_d;
   logic               do_commit, do_issue, mispredict;

   logic               cv_q, cv_d, cs_q, cs_d, clr_q, clr_d;
   logic [REG_W-1:0]   cid_q, cid_d;
   logic [XLEN-1:0]    cdata_q, cdata_d, redir_q, redir_d;
   logic [ROB_BIT-1:0] cent_q, cent_d;

   assign head_ent   = ent_q[head_q];
   assign rob_full   = (count_q == (ROB_BIT+1)'(ROB_SIZE));
   assign do_commit  = rdy_in && !halt_q && head_ent.busy && head_ent.ready;
   assign mispredict = do_commit && (head_ent.rtype == ROB_BR) &&
                       (head_ent.taken != head_ent.pred_taken);
   // A flushing edge drops whatever issues alongside it.
   assign do_issue   = rdy_in && issue_valid && !rob_full && !mispredict;

   always_comb begin
      ent_d   = ent_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      halt_d  = halt_q;
      if (rdy_in) begin
         if (alu_valid && ent_q[alu_rob_entry].busy) begin
            ent_d[alu_rob_entry].ready = 1'b1;
            ent_d[alu_rob_entry].val   = alu_val;
            if (ent_q[alu_rob_entry].rtype == ROB_BR) begin
               ent_d[alu_rob_entry].taken = alu_taken;
            end
         end
         if (lsb_valid && ent_q[lsb_rob_entry].busy) begin
            ent_d[lsb_rob_entry].ready = 1'b1;
            ent_d[lsb_rob_entry].val   = lsb_val;
         end
         if (do_commit) begin
            ent_d[head_q].busy = 1'b0;
            head_d             = head_q + ROB_BIT'(1);
            if (head_ent.rtype == ROB_EXIT) begin
               halt_d = 1'b1;
            end
         end
         if (do_issue) begin
            ent_d[tail_q].busy       = 1'b1;
            ent_d[tail_q].ready      = issue_ready;
            ent_d[tail_q].rtype      = rob_type_e'(issue_type);
            ent_d[tail_q].rd         = issue_rd;
            ent_d[tail_q].pc         = issue_pc;
            ent_d[tail_q].pred_taken = issue_pred_taken;
            ent_d[tail_q].taken      = 1'b0;
            ent_d[tail_q].val        = issue_val;
            tail_d                   = tail_q + ROB_BIT'(1);
         end
         case ({do_issue, do_commit})
            2'b10:   count_d = count_q + (ROB_BIT+1)'(1);
            2'b01:   count_d = count_q - (ROB_BIT+1)'(1);
            default: count_d = count_q;
         endcase
         if (mispredict) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
               ent_d[i].busy  = 1'b0;
               ent_d[i].ready = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end
      end
   end

   always_comb begin
      cv_d    = do_commit;
      cid_d   = (do_commit && head_ent.rtype == ROB_REG) ? head_ent.rd : '0;
      cdata_d = do_commit ? head_ent.val : '0;
      cent_d  = do_commit ? head_q : '0;
      cs_d    = do_commit && (head_ent.rtype == ROB_STORE);
      clr_d   = mispredict;
      redir_d = '0;
      if (mispredict) begin
         redir_d = head_ent.taken ? head_ent.val : head_ent.pc + 32'd4;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            ent_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         halt_q  <= 1'b0;
         cv_q    <= 1'b0;
         cid_q   <= '0;
         cdata_q <= '0;
         cent_q  <= '0;
         cs_q    <= 1'b0;
         clr_q   <= 1'b0;
         redir_q <= '0;
      end else begin
         ent_q   <= ent_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         halt_q  <= halt_d;
         cv_q    <= cv_d;
         cid_q   <= cid_d;
         cdata_q <= cdata_d;
         cent_q  <= cent_d;
         cs_q    <= cs_d;
         clr_q   <= clr_d;
         redir_q <= redir_d;
      end
   end

`ifdef ROB_STATS_EN
   logic [31:0] stat_commits_q, stat_flushes_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         stat_commits_q <= '0;
         stat_flushes_q <= '0;
      end else begin
         if (do_commit)  stat_commits_q <= stat_commits_q + 32'd1;
         if (mispredict) stat_flushes_q <= stat_flushes_q + 32'd1;
      end
   end

   assign stat_commits = stat_commits_q;
   assign stat_flushes = stat_flushes_q;
`endif

   assign issue_rob_entry  = tail_q;
   assign commit_valid     = cv_q;
   assign commit_reg_id    = cid_q;
   assign commit_reg_data  = cdata_q;
   assign commit_rob_entry = cent_q;
   assign commit_store     = cs_q;
   assign rob_clear_up     = clr_q;
   assign redirect_pc      = redir_q;
   assign halt             = halt_q;

   rob_bypass #(.ROB_BIT(ROB_BIT)) u_q1 (
      .q_entry_i       (q1_entry),
      .entry_busy_i    (ent_q[q1_entry].busy),
      .entry_ready_i   (ent_q[q1_entry].ready),
      .entry_val_i     (ent_q[q1_entry].val),
      .alu_valid_i     (alu_valid),
      .alu_rob_entry_i (alu_rob_entry),
      .alu_val_i       (alu_val),
      .lsb_valid_i     (lsb_valid),
      .lsb_rob_entry_i (lsb_rob_entry),
      .lsb_val_i       (lsb_val),
      .q_ready_o       (q1_ready),
      .q_val_o         (q1_val)
   );

   rob_bypass #(.ROB_BIT(ROB_BIT)) u_q2 (
      .q_entry_i       (q2_entry),
      .entry_busy_i    (ent_q[q2_entry].busy),
      .entry_ready_i   (ent_q[q2_entry].ready),
      .entry_val_i     (ent_q[q2_entry].val),
      .alu_valid_i     (alu_valid),
      .alu_rob_entry_i (alu_rob_entry),
      .alu_val_i       (alu_val),
      .lsb_valid_i     (lsb_valid),
      .lsb_rob_entry_i (lsb_rob_entry),
      .lsb_val_i       (lsb_val),
      .q_ready_o       (q2_ready),
      .q_val_o         (q2_val)
   );

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against an in-order queue model.
module tb_reorder_buffer;

   localparam logic [1:0] T_REG = 2'd0, T_STORE = 2'd1, T_BR = 2'd2, T_EXIT = 2'd3;

   logic        clk_in, rst_in, rdy_in;
   logic        issue_valid, issue_pred_taken, issue_ready;
   logic [1:0]  issue_type;
   logic [4:0]  issue_rd;
   logic [31:0] issue_pc, issue_val;
   logic [4:0]  issue_rob_entry;
   logic        rob_full;
   logic        alu_valid, lsb_valid, alu_taken;
   logic [4:0]  alu_rob_entry, lsb_rob_entry;
   logic [31:0] alu_val, lsb_val;
   logic [4:0]  q1_entry, q2_entry;
   logic        q1_ready, q2_ready;
   logic [31:0] q1_val, q2_val;
   logic        commit_valid, commit_store, rob_clear_up, halt;
   logic [4:0]  commit_reg_id, commit_rob_entry;
   logic [31:0] commit_reg_data, redirect_pc;
`ifdef ROB_STATS_EN
   logic [31:0] stat_commits, stat_flushes;
`endif

   reorder_buffer dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
      .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken), .issue_ready(issue_ready),
      .issue_val(issue_val), .issue_rob_entry(issue_rob_entry), .rob_full(rob_full),
      .alu_valid(alu_valid), .alu_rob_entry(alu_rob_entry), .alu_val(alu_val), .alu_taken(alu_taken),
      .lsb_valid(lsb_valid), .lsb_rob_entry(lsb_rob_entry), .lsb_val(lsb_val),
      .q1_entry(q1_entry), .q2_entry(q2_entry), .q1_ready(q1_ready), .q2_ready(q2_ready),
      .q1_val(q1_val), .q2_val(q2_val),
      .commit_valid(commit_valid), .commit_reg_id(commit_reg_id), .commit_reg_data(commit_reg_data),
      .commit_rob_entry(commit_rob_entry), .commit_store(commit_store),
      .rob_clear_up(rob_clear_up), .redirect_pc(redirect_pc), .halt(halt)
`ifdef ROB_STATS_EN
      , .stat_commits(stat_commits), .stat_flushes(stat_flushes)
`endif
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [4:0]  tag;
      logic [1:0]  typ;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        pred, ready, taken;
      logic [31:0] val;
   } ment_t;

   ment_t       mq[$];
   logic [4:0]  m_tail;
   logic        m_halt;
   logic        e_cv, e_store, e_clr;
   logic [4:0]  e_id, e_entry;
   logic [31:0] e_data, e_redir;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic q_model(input logic [4:0] e, output logic r, output logic [31:0] v);
      r = 1'b0;
      v = '0;
      foreach (mq[i]) begin
         if (mq[i].tag == e) begin
            if (lsb_valid && lsb_rob_entry == e) begin
               r = 1'b1; v = lsb_val;
            end else if (alu_valid && alu_rob_entry == e) begin
               r = 1'b1; v = alu_val;
            end else begin
               r = mq[i].ready; v = mq[i].val;
            end
         end
      end
   endtask

   task automatic check_outputs();
      logic        r;
      logic [31:0] v;
      chk("rob_full", rob_full, mq.size() == 32);
      chk("issue_rob_entry", issue_rob_entry, m_tail);
      chk("halt", halt, m_halt);
      chk("commit_valid", commit_valid, e_cv);
      chk("commit_reg_id", commit_reg_id, e_id);
      chk("commit_reg_data", commit_reg_data, e_data);
      chk("commit_rob_entry", commit_rob_entry, e_entry);
      chk("commit_store", commit_store, e_store);
      chk("rob_clear_up", rob_clear_up, e_clr);
      chk("redirect_pc", redirect_pc, e_redir);
      q_model(q1_entry, r, v);
      chk("q1_ready", q1_ready, r);
      if (r) chk("q1_val", q1_val, v);
      q_model(q2_entry, r, v);
      chk("q2_ready", q2_ready, r);
      if (r) chk("q2_val", q2_val, v);
   endtask

   // Advance the model across one rising edge using the inputs currently driven.
   task automatic model_edge();
      int   sz;
      logic c, mis;
      ment_t n;
      e_cv = 0; e_id = 0; e_data = 0; e_entry = 0; e_store = 0; e_clr = 0; e_redir = 0;
      if (!rdy_in) return;
      sz  = mq.size();
      c   = (sz > 0) && mq[0].ready && !m_halt;
      mis = 1'b0;
      if (c) begin
         e_cv    = 1'b1;
         e_id    = (mq[0].typ == T_REG) ? mq[0].rd : 5'd0;
         e_data  = mq[0].val;
         e_entry = mq[0].tag;
         e_store = (mq[0].typ == T_STORE);
         mis     = (mq[0].typ == T_BR) && (mq[0].taken != mq[0].pred);
         e_clr   = mis;
         if (mis) e_redir = mq[0].taken ? mq[0].val : mq[0].pc + 32'd4;
      end
      foreach (mq[i]) begin
         if (alu_valid && mq[i].tag == alu_rob_entry) begin
            mq[i].ready = 1'b1;
            mq[i].val   = alu_val;
            if (mq[i].typ == T_BR) mq[i].taken = alu_taken;
         end
      end
      foreach (mq[i]) begin
         if (lsb_valid && mq[i].tag == lsb_rob_entry) begin
            mq[i].ready = 1'b1;
            mq[i].val   = lsb_val;
         end
      end
      if (c) begin
         if (mq[0].typ == T_EXIT) m_halt = 1'b1;
         void'(mq.pop_front());
      end
      if (issue_valid && sz < 32 && !mis) begin
         n.tag = m_tail; n.typ = issue_type; n.rd = issue_rd; n.pc = issue_pc;
         n.pred = issue_pred_taken; n.ready = issue_ready; n.taken = 1'b0; n.val = issue_val;
         mq.push_back(n);
         m_tail = m_tail + 5'd1;
      end
      if (mis) begin
         mq.delete();
         m_tail = '0;
      end
   endtask

   task automatic step();
      @(negedge clk_in);
      check_outputs();
      model_edge();
      @(posedge clk_in);
      #1;
      issue_valid = 1'b0;
      alu_valid   = 1'b0;
      lsb_valid   = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk_in);
      #3;
      rst_in = 1'b0;
      issue_valid = 1'b0; alu_valid = 1'b0; lsb_valid = 1'b0;
      #1;
      chk("rst_rob_full", rob_full, 0);
      chk("rst_issue_rob_entry", issue_rob_entry, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_commit_reg_id", commit_reg_id, 0);
      chk("rst_commit_reg_data", commit_reg_data, 0);
      chk("rst_commit_rob_entry", commit_rob_entry, 0);
      chk("rst_commit_store", commit_store, 0);
      chk("rst_rob_clear_up", rob_clear_up, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_halt", halt, 0);
      chk("rst_q1_ready", q1_ready, 0);
      chk("rst_q2_val", q2_val, 0);
      mq.delete();
      m_tail = '0; m_halt = 1'b0;
      e_cv = 0; e_id = 0; e_data = 0; e_entry = 0; e_store = 0; e_clr = 0; e_redir = 0;
      @(negedge clk_in);
      rst_in = 1'b1;
      @(posedge clk_in);
      #1;
   endtask

   task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                        input logic pred, input logic rdy, input logic [31:0] v);
      issue_valid = 1'b1; issue_type = t; issue_rd = rd; issue_pc = pc;
      issue_pred_taken = pred; issue_ready = rdy; issue_val = v;
      step();
   endtask

   task automatic alu_wb(input logic [4:0] tag, input logic [31:0] v, input logic tk);
      alu_valid = 1'b1; alu_rob_entry = tag; alu_val = v; alu_taken = tk;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1;
      issue_valid = 0; issue_type = 0; issue_rd = 0; issue_pc = 0;
      issue_pred_taken = 0; issue_ready = 0; issue_val = 0;
      alu_valid = 0; alu_rob_entry = 0; alu_val = 0; alu_taken = 0;
      lsb_valid = 0; lsb_rob_entry = 0; lsb_val = 0;
      q1_entry = 0; q2_entry = 0;
      do_reset();

      // Single REG instruction: writeback then commit one edge later.
      issue(T_REG, 5'd3, 32'h0, 1'b0, 1'b0, 32'h0);
      alu_wb(5'd0, 32'hDEADBEEF, 1'b0);
      step();
      chk("t2_commit_valid", commit_valid, 1);
      chk("t2_commit_reg_id", commit_reg_id, 3);
      chk("t2_commit_reg_data", commit_reg_data, 32'hDEADBEEF);
      chk("t2_commit_rob_entry", commit_rob_entry, 0);
      step();

      // Out-of-order writeback still retires in order.
      issue(T_REG, 5'd5, 32'h4, 1'b0, 1'b0, 32'h0);
      issue(T_REG, 5'd6, 32'h8, 1'b0, 1'b0, 32'h0);
      alu_wb(5'd2, 32'h22, 1'b0);
      step();
      step();
      chk("t3_no_commit", commit_valid, 0);
      alu_wb(5'd1, 32'h11, 1'b0);
      step();
      chk("t3_first_entry", commit_rob_entry, 1);
      step();
      chk("t3_second_entry", commit_rob_entry, 2);
      chk("t3_second_data", commit_reg_data, 32'h22);
      step();

      // Reset while five entries are in flight.
      for (int i = 0; i < 5; i++) issue(T_STORE, 5'd0, 32'h40 + 32'(i), 1'b0, 1'b0, 32'h0);
      do_reset();

      // Fill to capacity, reject the extra issue, free one slot.
      for (int i = 0; i < 32; i++) issue(T_REG, 5'(i), 32'(i * 4), 1'b0, 1'b0, 32'h0);
      chk("t4_full", rob_full, 1);
      issue(T_REG, 5'd9, 32'h999, 1'b0, 1'b0, 32'h0);
      chk("t4_tail_stays", issue_rob_entry, 0);
      alu_wb(5'd0, 32'h1234, 1'b0);
      step();
      chk("t4_not_full", rob_full, 0);

      // Same-cycle CDB forwarding on a query port.
      q1_entry = 5'd4; q2_entry = 5'd5;
      alu_valid = 1'b1; alu_rob_entry = 5'd4; alu_val = 32'd7;
      #1;
      chk("t6_q1_ready", q1_ready, 1);
      chk("t6_q1_val", q1_val, 7);
      chk("t6_q2_ready", q2_ready, 0);
      step();

      // Mispredicted taken branch flushes younger entries.
      do_reset();
      issue(T_BR, 5'd0, 32'h100, 1'b0, 1'b0, 32'h0);
      issue(T_REG, 5'd1, 32'h104, 1'b0, 1'b0, 32'h0);
      issue(T_REG, 5'd2, 32'h108, 1'b0, 1'b1, 32'h55);
      alu_wb(5'd0, 32'h200, 1'b1);
      step();
      chk("t5_clear_up", rob_clear_up, 1);
      chk("t5_redirect", redirect_pc, 32'h200);
      chk("t5_reg_id", commit_reg_id, 0);
      chk("t5_tail", issue_rob_entry, 0);
      q1_entry = 5'd2;
      #1;
      chk("t5_q1_cleared", q1_ready, 0);
      step();

      // Predicted-taken branch that falls through, PC wraps past 2^32.
      issue(T_BR, 5'd0, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h0);
      alu_wb(5'd0, 32'h40, 1'b0);
      step();
      chk("t5b_redirect_wrap", redirect_pc, 32'h0);

      // rdy_in low freezes everything.
      issue(T_REG, 5'd7, 32'h10, 1'b0, 1'b1, 32'h77);
      rdy_in = 1'b0;
      issue(T_REG, 5'd8, 32'h14, 1'b0, 1'b1, 32'h88);
      step();
      chk("t7_hold_commit", commit_valid, 0);
      rdy_in = 1'b1;
      step();
      step();

      // EXIT halts and blocks later commits.
      issue(T_EXIT, 5'd0, 32'h20, 1'b0, 1'b1, 32'h0);
      issue(T_REG, 5'd9, 32'h24, 1'b0, 1'b1, 32'h99);
      step();
      step();
      chk("t8_halt", halt, 1);
      chk("t8_blocked", commit_valid, 0);

      // Random traffic.
      do_reset();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         logic [1:0] t;
         rdy_in      = ($urandom_range(0, 9) != 0);
         issue_valid = ($urandom_range(0, 9) < 6);
         t           = 2'($urandom_range(0, 3));
         if (t == T_EXIT && $urandom_range(0, 15) != 0) t = T_REG;
         issue_type       = t;
         issue_rd         = 5'($urandom_range(0, 31));
         issue_pc         = $urandom;
         issue_pred_taken = 1'($urandom_range(0, 1));
         issue_ready      = ($urandom_range(0, 3) == 0);
         issue_val        = $urandom;
         alu_valid        = ($urandom_range(0, 1) == 1);
         alu_rob_entry    = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag
                                            : 5'($urandom_range(0, 31));
         alu_val          = $urandom;
         alu_taken        = 1'($urandom_range(0, 1));
         lsb_valid        = ($urandom_range(0, 2) == 0);
         lsb_rob_entry    = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag
                                            : 5'($urandom_range(0, 31));
         lsb_val          = $urandom;
         if (alu_valid && lsb_valid && alu_rob_entry == lsb_rob_entry) lsb_valid = 1'b0;
         q1_entry = (mq.size() > 0) ? mq[$urandom_range(0, mq.size() - 1)].tag
                                    : 5'($urandom_range(0, 31));
         q2_entry = 5'($urandom_range(0, 31));
         step();
         if (m_halt && $urandom_range(0, 19) == 0) do_reset();
      end
      rdy_in = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
